puf_eval_ctrl: RTL and testbench

- Sequences evaluations of the dual-mode arbiter PUF chain (N-stage demux/mux array terminated by the reset-able latch).
- Per challenge: applies the challenge to the select bus, then runs NUM_EVALS arm/fire/sample cycles and majority-votes them into one response bit.
- Host side uses valid/ready handshakes for challenge in and response out.
- Sits between the PUF core and the host/register interface.

---
 rtl/puf_pkg.sv | 24 ++
 rtl/sync2.sv | 33 +++
 rtl/puf_eval_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types, default parameters and helpers for the arbiter-PUF evaluation controller.
// Optional build macro used by the controller: PUF_STABILITY_FLAG_EN.
package puf_pkg;

   localparam int unsigned PUF_N_DEF             = 128;
   localparam int unsigned PUF_NUM_EVALS_DEF     = 5;
   localparam int unsigned PUF_RST_CYCLES_DEF    = 2;
   localparam int unsigned PUF_SETTLE_CYCLES_DEF = 8;
   localparam int unsigned PUF_UNSTABLE_CNT_W    = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      FIRE   = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } state_e;

   // Smallest count of ones that wins the majority vote over n evaluations.
   function automatic int unsigned maj_thresh(input int unsigned n);
      return (n / 2) + 1;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous PUF outputs.
module sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   // Shift the asynchronous input through the two stages.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: arm/fire/sample NUM_EVALS times per
// challenge and majority-vote the synchronized latch output into one bit.
// Optional build macro: PUF_STABILITY_FLAG_EN adds resp_unstable and a
// saturating count of unstable responses (unstable_cnt).
module puf_eval_ctrl
   import puf_pkg::*;
#(
   parameter int unsigned N             = PUF_N_DEF,
   parameter int unsigned NUM_EVALS     = PUF_NUM_EVALS_DEF,
   parameter int unsigned RST_CYCLES    = PUF_RST_CYCLES_DEF,
   parameter int unsigned SETTLE_CYCLES = PUF_SETTLE_CYCLES_DEF
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             chal_valid,
   output logic                             chal_ready,
   input  logic [N-1:0]                     chal_data,
   input  logic                             abort,
   output logic                             resp_valid,
   input  logic                             resp_ready,
   output logic                             resp_bit,
   output logic [$clog2(NUM_EVALS+1)-1:0]   resp_ones,
   output logic                             busy,
   output logic [N-1:0]                     puf_sel,
   output logic                             puf_in,
   output logic                             puf_reset,
   input  logic                             puf_out
`ifdef PUF_STABILITY_FLAG_EN
   ,
   output logic                             resp_unstable,
   output logic [PUF_UNSTABLE_CNT_W-1:0]    unstable_cnt
`endif
);

   localparam int unsigned ONES_W  = $clog2(NUM_EVALS + 1);
   localparam int unsigned EVAL_W  = (NUM_EVALS > 1) ? $clog2(NUM_EVALS) : 1;
   localparam int unsigned CYC_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
   localparam int unsigned THRESH  = maj_thresh(NUM_EVALS);

   // Reject parameter sets that would make the vote or timing meaningless.
   if ((NUM_EVALS < 1) || ((NUM_EVALS % 2) == 0)) begin : g_bad_num_evals
      $error("NUM_EVALS must be odd and >= 1");
   end
   if (RST_CYCLES < 1) begin : g_bad_rst_cycles
      $error("RST_CYCLES must be >= 1");
   end
   if (SETTLE_CYCLES < 3) begin : g_bad_settle_cycles
      $error("SETTLE_CYCLES must be >= 3");
   end

   state_e              state_q, state_d;
   logic [CYC_W-1:0]    cyc_q, cyc_d;
   logic [EVAL_W-1:0]   eval_q, eval_d;
   logic [ONES_W-1:0]   ones_q, ones_d;
   logic [N-1:0]        sel_q, sel_d;
   logic                puf_in_q, puf_in_d;
   logic                puf_reset_q, puf_reset_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_bit_q, resp_bit_d;
   logic [ONES_W-1:0]   resp_ones_q, resp_ones_d;
   logic                sync_out;

   // Bring the raw latch output into the clk domain.
   sync2 #(.WIDTH(1)) u_sync2 (
      .clk   (clk),
      .rst_n (reset),
      .d     (puf_out),
      .q     (sync_out)
   );

   // Next-state, counters and registered output values.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      eval_d  = eval_q;
      ones_d  = ones_q;
      sel_d   = sel_q;

      case (state_q)
         IDLE: begin
            if (chal_valid) begin
               sel_d   = chal_data;
               ones_d  = '0;
               eval_d  = '0;
               cyc_d   = '0;
               state_d = ARM;
            end
         end
         ARM: begin
            if (cyc_q == CYC_W'(RST_CYCLES - 1)) begin
               cyc_d   = '0;
               state_d = FIRE;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         FIRE: begin
            if (cyc_q == CYC_W'(SETTLE_CYCLES - 1)) begin
               cyc_d   = '0;
               state_d = SAMPLE;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         SAMPLE: begin
            ones_d = ones_q + ONES_W'(sync_out);
            if (eval_q == EVAL_W'(NUM_EVALS - 1)) begin
               state_d = DONE;
            end else begin
               eval_d  = eval_q + EVAL_W'(1);
               state_d = ARM;
            end
         end
         DONE: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort only cancels an evaluation in flight; a finished response is kept.
      if (abort && ((state_q == ARM) || (state_q == FIRE) || (state_q == SAMPLE))) begin
         state_d = IDLE;
         cyc_d   = '0;
         eval_d  = '0;
         ones_d  = '0;
      end

      puf_reset_d  = (state_d == IDLE) || (state_d == ARM);
      puf_in_d     = (state_d == FIRE);
      resp_valid_d = (state_d == DONE);
      resp_bit_d   = resp_valid_d && (ones_d >= ONES_W'(THRESH));
      resp_ones_d  = resp_valid_d ? ones_d : '0;
   end

   // State, counters and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cyc_q        <= '0;
         eval_q       <= '0;
         ones_q       <= '0;
         sel_q        <= '0;
         puf_in_q     <= 1'b0;
         puf_reset_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_bit_q   <= 1'b0;
         resp_ones_q  <= '0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         eval_q       <= eval_d;
         ones_q       <= ones_d;
         sel_q        <= sel_d;
         puf_in_q     <= puf_in_d;
         puf_reset_q  <= puf_reset_d;
         resp_valid_q <= resp_valid_d;
         resp_bit_q   <= resp_bit_d;
         resp_ones_q  <= resp_ones_d;
      end
   end

   assign chal_ready = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign puf_sel    = sel_q;
   assign puf_in     = puf_in_q;
   assign puf_reset  = puf_reset_q;
   assign resp_valid = resp_valid_q;
   assign resp_bit   = resp_bit_q;
   assign resp_ones  = resp_ones_q;

`ifdef PUF_STABILITY_FLAG_EN
   logic                          resp_unstable_q, resp_unstable_d;
   logic [PUF_UNSTABLE_CNT_W-1:0] unstable_cnt_q, unstable_cnt_d;

   // Flag mixed votes and count them, saturating, on each response handshake.
   always_comb begin
      resp_unstable_d = (state_d == DONE) && (ones_d != '0) && (ones_d != ONES_W'(NUM_EVALS));
      unstable_cnt_d  = unstable_cnt_q;
      if ((state_q == DONE) && resp_ready && resp_unstable_q &&
          (unstable_cnt_q != {PUF_UNSTABLE_CNT_W{1'b1}})) begin
         unstable_cnt_d = unstable_cnt_q + PUF_UNSTABLE_CNT_W'(1);
      end
   end

   // Stability flag and sticky counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_unstable_q <= 1'b0;
         unstable_cnt_q  <= '0;
      end else begin
         resp_unstable_q <= resp_unstable_d;
         unstable_cnt_q  <= unstable_cnt_d;
      end
   end

   assign resp_unstable = resp_unstable_q;
   assign unstable_cnt  = unstable_cnt_q;
`endif

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl with a mock PUF latch and timing monitor.
module tb_puf_eval_ctrl;

   localparam int unsigned N   = 128;
   localparam int unsigned NE  = 5;
   localparam int unsigned RC  = 2;
   localparam int unsigned SC  = 8;
   localparam int unsigned LAT = NE * (RC + SC + 1);

   logic          clk;
   logic          reset;
   logic          chal_valid;
   logic          chal_ready;
   logic [N-1:0]  chal_data;
   logic          abort;
   logic          resp_valid;
   logic          resp_ready;
   logic          resp_bit;
   logic [2:0]    resp_ones;
   logic          busy;
   logic [N-1:0]  puf_sel;
   logic          puf_in;
   logic          puf_reset;
   logic          puf_out;
`ifdef PUF_STABILITY_FLAG_EN
   logic          resp_unstable;
   logic [15:0]   unstable_cnt;
   int            exp_ucnt = 0;
`endif

   int checks   = 0;
   int failures = 0;

   // Mock PUF / monitor state
   logic [7:0] pattern;
   int         rises    = 0;
   int         bad_pre  = 0;
   int         bad_fire = 0;
   int         rst_run  = 0;
   int         fire_run = 0;
   bit         prev_in  = 1'b0;
   bit         cur_bit  = 1'b0;

   typedef struct {
      logic [N-1:0] chal;
      logic [7:0]   pat;
      logic         exp_bit;
      logic [2:0]   exp_ones;
      logic         exp_unst;
   } vec_t;

   vec_t vecs[6];

   puf_eval_ctrl #(
      .N(N), .NUM_EVALS(NE), .RST_CYCLES(RC), .SETTLE_CYCLES(SC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .chal_valid (chal_valid),
      .chal_ready (chal_ready),
      .chal_data  (chal_data),
      .abort      (abort),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_bit   (resp_bit),
      .resp_ones  (resp_ones),
      .busy       (busy),
      .puf_sel    (puf_sel),
      .puf_in     (puf_in),
      .puf_reset  (puf_reset),
      .puf_out    (puf_out)
`ifdef PUF_STABILITY_FLAG_EN
      ,
      .resp_unstable (resp_unstable),
      .unstable_cnt  (unstable_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Mock latch (output = pattern bit of the current evaluation while fired)
   // plus launch-timing monitor, all evaluated mid-cycle.
   always @(negedge clk) begin
      if (chal_ready) begin
         rises    = 0;
         bad_pre  = 0;
         bad_fire = 0;
      end
      if (puf_in && !prev_in) begin
         cur_bit = (rises < 8) ? pattern[rises[2:0]] : 1'b0;
         if (rst_run < int'(RC)) bad_pre++;
         rises++;
         fire_run = 0;
      end
      if (!puf_in && prev_in) begin
         if (fire_run != int'(SC)) bad_fire++;
      end
      if (puf_in) fire_run++;
      rst_run = puf_reset ? rst_run + 1 : 0;
      puf_out = puf_in ? cur_bit : 1'b0;
      prev_in = puf_in;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic accept(input string tag, input logic [N-1:0] chal, input logic [7:0] pat);
      int w = 0;
      while (!chal_ready && w < 100) begin tick(); w++; end
      pattern    = pat;
      chal_data  = chal;
      chal_valid = 1'b1;
      tick();
      chal_valid = 1'b0;
      check({tag, "_accept_busy"}, 128'(busy), 128'(1'b1));
   endtask

   task automatic wait_resp(input string tag, input logic [N-1:0] chal,
                            input logic eb, input logic [2:0] eo, input logic eu);
      int cyc = 0;
      int sel_bad = 0;
      while (!resp_valid && cyc < 200) begin
         tick();
         cyc++;
         if (puf_sel !== chal) sel_bad++;
      end
      check({tag, "_latency"},   128'(cyc),      128'(LAT));
      check({tag, "_sel_held"},  128'(sel_bad),  128'(0));
      check({tag, "_resp_bit"},  128'(resp_bit), 128'(eb));
      check({tag, "_resp_ones"}, 128'(resp_ones), 128'(eo));
      check({tag, "_fires"},     128'(rises),    128'(NE));
      check({tag, "_pre_reset"}, 128'(bad_pre),  128'(0));
      check({tag, "_fire_len"},  128'(bad_fire), 128'(0));
`ifdef PUF_STABILITY_FLAG_EN
      check({tag, "_unstable"},  128'(resp_unstable), 128'(eu));
      if (eu) exp_ucnt++;
`else
      if (eu) begin end
`endif
   endtask

   task automatic handshake(input string tag);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check({tag, "_valid_drop"}, 128'(resp_valid), 128'(1'b0));
      check({tag, "_idle_ready"}, 128'(chal_ready), 128'(1'b1));
`ifdef PUF_STABILITY_FLAG_EN
      check({tag, "_ucnt"}, 128'(unstable_cnt), 128'(exp_ucnt));
`endif
   endtask

   initial begin
      logic [N-1:0] c_a;
      logic [N-1:0] c_b;
      int w;
      int stable_bad;
      int seen_valid;

      vecs[0] = '{{16{8'hA5}},                              8'b0001_1111, 1'b1, 3'd5, 1'b0};
      vecs[1] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 8'b0001_0101, 1'b1, 3'd3, 1'b1};
      vecs[2] = '{{N{1'b1}},                                8'b0000_0000, 1'b0, 3'd0, 1'b0};
      vecs[3] = '{128'h1,                                   8'b0000_0011, 1'b0, 3'd2, 1'b1};
      vecs[4] = '{128'h8000_0000_0000_0000_0000_0000_0000_0001, 8'b0000_0111, 1'b1, 3'd3, 1'b1};
      vecs[5] = '{128'hDEAD_BEEF_0000_0000_CAFE_F00D_1234_5678, 8'b0001_0000, 1'b0, 3'd1, 1'b1};

      reset      = 1'b0;
      chal_valid = 1'b0;
      chal_data  = '0;
      abort      = 1'b0;
      resp_ready = 1'b0;
      pattern    = '0;

      // Reset values
      tick(3);
      check("rst_puf_reset",  128'(puf_reset),  128'(1'b1));
      check("rst_chal_ready", 128'(chal_ready), 128'(1'b1));
      check("rst_puf_in",     128'(puf_in),     128'(1'b0));
      check("rst_busy",       128'(busy),       128'(1'b0));
      check("rst_resp_valid", 128'(resp_valid), 128'(1'b0));
      check("rst_resp_bit",   128'(resp_bit),   128'(1'b0));
      check("rst_resp_ones",  128'(resp_ones),  128'(0));
      check("rst_puf_sel",    128'(puf_sel),    128'(0));
      reset = 1'b1;
      tick(2);

      // Table-driven evaluations
      for (int i = 0; i < 6; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         accept(tag, vecs[i].chal, vecs[i].pat);
         wait_resp(tag, vecs[i].chal, vecs[i].exp_bit, vecs[i].exp_ones, vecs[i].exp_unst);
         handshake(tag);
      end

      // Back-pressure: response held, new challenge and abort ignored while DONE
      c_a = {4{32'h1357_9BDF}};
      c_b = {4{32'h2468_ACE0}};
      accept("bp", c_a, 8'b0001_0101);
      wait_resp("bp", c_a, 1'b1, 3'd3, 1'b1);
      chal_data  = c_b;
      chal_valid = 1'b1;
      abort      = 1'b1;
      stable_bad = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (k == 4) abort = 1'b0;
         if (resp_valid !== 1'b1 || resp_bit !== 1'b1 || resp_ones !== 3'd3 ||
             chal_ready !== 1'b0 || puf_sel !== c_a) stable_bad++;
      end
      check("bp_stable", 128'(stable_bad), 128'(0));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
`ifdef PUF_STABILITY_FLAG_EN
      check("bp_ucnt", 128'(unstable_cnt), 128'(exp_ucnt));
`endif
      check("bp_hs_valid", 128'(resp_valid), 128'(1'b0));
      check("bp_hs_idle",  128'(chal_ready), 128'(1'b1));
      check("bp_hs_sel",   128'(puf_sel),    128'(c_a));
      tick();
      chal_valid = 1'b0;
      check("bp_next_busy", 128'(busy),    128'(1'b1));
      check("bp_next_sel",  128'(puf_sel), 128'(c_b));
      wait_resp("bp2", c_b, 1'b1, 3'd3, 1'b1);
      handshake("bp2");

      // Abort during the third fire phase
      accept("ab", c_a, 8'b0000_0011);
      w = 0;
      while (!(rises == 3 && puf_in) && w < 100) begin tick(); w++; end
      check("ab_reached_fire3", 128'(w < 100), 128'(1'b1));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_idle",      128'(chal_ready), 128'(1'b1));
      check("ab_puf_in",    128'(puf_in),     128'(1'b0));
      check("ab_puf_reset", 128'(puf_reset),  128'(1'b1));
      seen_valid = 0;
      for (int k = 0; k < 10; k++) begin
         if (resp_valid) seen_valid++;
         tick();
      end
      check("ab_no_resp", 128'(seen_valid), 128'(0));
      accept("ab2", c_b, 8'b0000_0011);
      wait_resp("ab2", c_b, 1'b0, 3'd2, 1'b1);
      handshake("ab2");

      // Asynchronous reset while sampling
      accept("rs", c_a, 8'b0001_1111);
      w = 0;
      while (!(rises == 1 && !puf_in && busy) && w < 100) begin tick(); w++; end
      check("rs_reached_sample", 128'(w < 100), 128'(1'b1));
      #2 reset = 1'b0;
      #1;
      check("rs_puf_sel",    128'(puf_sel),    128'(0));
      check("rs_puf_reset",  128'(puf_reset),  128'(1'b1));
      check("rs_puf_in",     128'(puf_in),     128'(1'b0));
      check("rs_busy",       128'(busy),       128'(1'b0));
      check("rs_chal_ready", 128'(chal_ready), 128'(1'b1));
      check("rs_resp_valid", 128'(resp_valid), 128'(1'b0));
      check("rs_resp_ones",  128'(resp_ones),  128'(0));
`ifdef PUF_STABILITY_FLAG_EN
      check("rs_ucnt", 128'(unstable_cnt), 128'(0));
      exp_ucnt = 0;
`endif
      tick(2);
      reset = 1'b1;
      tick();
      accept("post", vecs[0].chal, vecs[0].pat);
      wait_resp("post", vecs[0].chal, 1'b1, 3'd5, 1'b0);
      handshake("post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
